// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - MIO bus responder: wait-stated word RAM, switch/LED register, free-running counter
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic [31:0] counter_out,
  output logic        bus_err
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0] WLOAD = WW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            state;
  logic [WW-1:0]     wcnt;
  logic [31:0]       mem [2**RAM_AW];

  logic              is_ram;
  logic              is_led;
  logic              is_cnt;
  logic              mapped;
  logic [RAM_AW-1:0] ram_idx;
  logic              enter_ready;
  logic              ram_we;
  logic [31:0]       rd_data;
  logic              unused_addr;

  // Byte-lane bits carry no meaning on a word bus.
  assign unused_addr = ^Addr_out[1:0];

  assign is_ram  = (Addr_out[31:28] == 4'h0);
  assign is_led  = (Addr_out[31:2] == 30'h3C00_0000);
  assign is_cnt  = (Addr_out[31:2] == 30'h3C00_0001);
  assign mapped  = is_ram | is_led | is_cnt;
  assign ram_idx = Addr_out[RAM_AW+1:2];

  // The edge entering READY is the single commit point for writes and read capture.
  assign enter_ready = !reset && CPU_MIO &&
                       (((state == S_IDLE) && !(is_ram && (WAIT_CYCLES > 0))) ||
                        ((state == S_WAIT) && (wcnt == '0)));
  assign ram_we = enter_ready && mem_w && is_ram;

  // Read data mux; counter value is the pre-increment one at the commit edge.
  always_comb begin
    rd_data = '0;
    if (is_ram)      rd_data = mem[ram_idx];
    else if (is_led) rd_data = {16'h0, sw_in};
    else if (is_cnt) rd_data = counter_out;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= Data_out;
  end

  // Handshake FSM, peripheral registers and free-running counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      MIO_ready   <= 1'b0;
      Data_in     <= '0;
      led_out     <= '0;
      counter_out <= '0;
      bus_err     <= 1'b0;
    end else begin
      counter_out <= counter_out + 32'd1;
      bus_err     <= 1'b0;
      if (enter_ready) begin
        state     <= S_READY;
        MIO_ready <= 1'b1;
        bus_err   <= !mapped;
        if (mem_w) begin
          if (is_led) led_out <= Data_out[15:0];
          if (is_cnt) counter_out <= Data_out;
        end else begin
          Data_in <= rd_data;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (CPU_MIO) begin
              state <= S_WAIT;
              wcnt  <= WLOAD;
            end
          end
          S_WAIT: begin
            if (!CPU_MIO) state <= S_IDLE;
            else          wcnt  <= wcnt - WW'(1);
          end
          S_READY: begin
            if (!CPU_MIO) begin
              state     <= S_IDLE;
              MIO_ready <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - scoreboard bench for mio_bus_responder
module tb_mio_bus_responder;
  localparam int RAM_AW      = 10;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_out = '0;
  logic [31:0] Data_out = '0;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic [31:0] counter_out;
  logic        bus_err;

  mio_bus_responder #(.RAM_AW(RAM_AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .sw_in(sw_in), .led_out(led_out),
    .counter_out(counter_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        berr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  logic [31:0] ram_m [int];
  logic [15:0] led_m = '0;
  logic [31:0] cb = '0, ob = '0;
  int          cb_cyc = 0, ob_cyc = 0;
  bit          chk_on = 1'b0;
  logic        prev_rdy = 1'b0;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference counter: value shown after edge c = last load value plus edges since the load.
  function automatic logic [31:0] cnt_at(input int c);
    if (c >= cb_cyc) return cb + 32'(c - cb_cyc);
    return ob + 32'(c - ob_cyc);
  endfunction

  // Monitor: counter every cycle, scoreboard pop on each new acknowledge, bus_err pulse shape.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("counter_out", counter_out, cnt_at(cyc));
      if (MIO_ready && !prev_rdy) begin
        if (sbq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_ack: got ack expected none (t=%0t)", $time);
        end else begin
          me = sbq.pop_front();
          if (me.rd) chk("Data_in", Data_in, me.data);
          chk("bus_err_first", {31'b0, bus_err}, {31'b0, me.berr});
        end
      end else begin
        chk("bus_err_other", {31'b0, bus_err}, 32'h0);
      end
    end
    prev_rdy = MIO_ready;
  end

  task automatic do_reset(input int n);
    chk_on  = 1'b0;
    reset   = 1'b1;
    CPU_MIO = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset  = 1'b0;
    cb     = '0;
    ob     = '0;
    cb_cyc = cyc;
    ob_cyc = cyc;
    led_m  = '0;
    chk_on = 1'b1;
  endtask

  // One full 4-phase transaction; caller is always just after a rising edge.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input logic [15:0] sw);
    bit   ram, led, cn, um;
    int   lat, k, n, idx;
    exp_t e;
    ram = (a[31:28] == 4'h0);
    led = (a[31:2] == 30'h3C00_0000);
    cn  = (a[31:2] == 30'h3C00_0001);
    um  = !(ram || led || cn);
    idx = int'(a[RAM_AW+1:2]);
    lat = ram ? 1 + WAIT_CYCLES : 1;
    n   = cyc;
    e.rd   = !w;
    e.berr = um;
    e.data = '0;
    if (!w) begin
      if (ram)      e.data = ram_m.exists(idx) ? ram_m[idx] : '0;
      else if (led) e.data = {16'h0, sw};
      else if (cn)  e.data = cnt_at(n + lat - 1);
    end
    sbq.push_back(e);
    if (w) begin
      if (ram) ram_m[idx] = d;
      if (led) led_m = d[15:0];
      if (cn) begin
        ob = cb; ob_cyc = cb_cyc;
        cb = d;  cb_cyc = n + lat;
      end
    end
    sw_in    = sw;
    mem_w    = w;
    Addr_out = a;
    Data_out = d;
    CPU_MIO  = 1'b1;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (MIO_ready) break;
    end
    if (!MIO_ready) begin
      vecs++;
      errs++;
      $display("FAIL ready_timeout: got no MIO_ready expected after %0d cycles (addr %h)", lat, a);
      void'(sbq.pop_back());
      CPU_MIO = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("led_out", {16'h0, led_out}, {16'h0, led_m});
    if (w && cn) chk("counter_load", counter_out, d);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("ready_hold", {31'b0, MIO_ready}, 32'h1);
    end
    CPU_MIO  = 1'b0;
    mem_w    = $urandom_range(0, 1);
    Addr_out = $urandom;
    Data_out = $urandom;
    @(posedge clk);
    #1;
    chk("ready_drop", {31'b0, MIO_ready}, 32'h0);
  endtask

  // RAM write abandoned in WAIT by dropping the request or by reset.
  task automatic abort_txn(input bit use_reset, input logic [31:0] a, input logic [31:0] d);
    mem_w    = 1'b1;
    Addr_out = a;
    Data_out = d;
    CPU_MIO  = 1'b1;
    @(posedge clk);
    #1;
    if (use_reset) begin
      do_reset(2);
      chk("abort_rst_ready", {31'b0, MIO_ready}, 32'h0);
      chk("abort_rst_data", Data_in, 32'h0);
    end else begin
      CPU_MIO = 1'b0;
      repeat (3) begin
        @(posedge clk);
        #1;
        chk("abort_no_ready", {31'b0, MIO_ready}, 32'h0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1);
  end

  initial begin
    bit          w;
    int          kind, idx;
    logic [31:0] a;

    do_reset(3);
    chk("rst_ready", {31'b0, MIO_ready}, 32'h0);
    chk("rst_data", Data_in, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_counter", counter_out, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'h0);

    do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 16'h0);
    do_txn(0, 32'h0000_0010, 32'h0, 0, 16'h0);
    do_txn(1, 32'hF000_0000, 32'h0001_A5A5, 0, 16'h0);
    chk("led_a5a5", {16'h0, led_out}, 32'h0000_A5A5);
    do_txn(0, 32'hF000_0000, 32'h0, 0, 16'h1234);
    do_txn(1, 32'hF000_0004, 32'hFFFF_FFFE, 2, 16'h0);
    do_txn(0, 32'hF000_0004, 32'h0, 0, 16'h0);
    do_txn(0, 32'h8000_0000, 32'h0, 0, 16'h0);
    do_txn(1, 32'h8000_0000, 32'h1234_5678, 1, 16'h0);
    do_txn(0, 32'h0000_0010, 32'h0, 0, 16'h0);
    do_txn(0, 32'hF000_0000, 32'h0, 0, 16'hBEEF);
    do_txn(1, 32'hF000_0004, 32'h0000_0100, 4, 16'h0);
    do_txn(1, 32'h0000_0020, 32'h1111_1111, 4, 16'h0);
    do_txn(0, 32'h0000_0020, 32'h0, 0, 16'h0);
    abort_txn(0, 32'h0000_0010, 32'hCAFE_F00D);
    do_txn(0, 32'h0000_0010, 32'h0, 0, 16'h0);
    abort_txn(1, 32'h0000_0010, 32'h0BAD_BAD0);
    do_txn(0, 32'h0000_0010, 32'h0, 0, 16'h0);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 7);
      w    = $urandom_range(0, 1);
      a    = $urandom;
      case (kind)
        0, 1: begin
          idx = $urandom_range(0, 15);
          a[31:28]       = 4'h0;
          a[RAM_AW+1:2]  = RAM_AW'(idx);
          if (!ram_m.exists(idx)) w = 1'b1;
        end
        2, 3: a = 32'hF000_0000 | 32'($urandom_range(0, 3));
        4, 5: a = 32'hF000_0004 | 32'($urandom_range(0, 3));
        default: begin
          if ($urandom_range(0, 3) == 0) a = 32'hF000_0008 + 32'($urandom_range(0, 100) << 2);
          else a[31:28] = 4'($urandom_range(1, 14));
        end
      endcase
      do_txn(w, a, $urandom, $urandom_range(0, 3), 16'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    @(posedge clk);
    #1;
    chk("queue_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
